// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: func3 codes for the M extension and the mul/div FSM state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_t;

  function automatic logic signed_a(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/shift_sub_core.sv
// Iterative datapath: shift-add multiply or restoring shift-subtract divide on operand magnitudes,
// one bit per step. acc holds {hi, lo}: product, or {remainder, quotient} when dividing.
module shift_sub_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic              sgn_a,
  input  logic              sgn_b,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc
);

  logic              div_q;
  logic [XLEN-1:0]   m;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   hi, lo, diff;
  logic [XLEN:0]     sum, rem_sh;
  logic              ge;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    mag_a = (sgn_a && a[XLEN-1]) ? -a : a;
    mag_b = (sgn_b && b[XLEN-1]) ? -b : b;
    hi    = acc[2*XLEN-1:XLEN];
    lo    = acc[XLEN-1:0];
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    // Remainder stays below the divisor, so the shifted value needs only one extra bit.
    rem_sh = {hi, lo[XLEN-1]};
    ge     = rem_sh >= {1'b0, m};
    diff   = rem_sh[XLEN-1:0] - m;
    if (div_q)
      acc_nxt = ge ? {diff, lo[XLEN-2:0], 1'b1} : {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    else
      acc_nxt = {sum, lo[XLEN-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      m     <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      div_q <= is_div;
      m     <= is_div ? mag_b : mag_a;
      acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
    end else if (step) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// RV32M multiply/divide sequencer: accepts one op, stalls the pipe while iterating, applies sign
// fixup and RISC-V corner-case results, then pulses done with a registered result.
module mul_div_sequencer
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state, nstate;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg_a, neg_b;
  logic [2*XLEN-1:0] acc;
  logic              accept, div_zero, ovf, special;
  logic [XLEN-1:0]   special_res, quo, rmd, fix_res;
  logic [2*XLEN-1:0] prod;

  assign accept   = (state == S_IDLE) && start && !flush;
  assign div_zero = func3[2] && (operandB == '0);
  assign ovf      = func3[2] && !func3[0] && (operandA == MIN_NEG) && (operandB == '1);
  assign special  = div_zero || ovf;

  always_comb begin
    if (div_zero) special_res = func3[1] ? operandA : '1;
    else          special_res = func3[1] ? '0 : MIN_NEG;
  end

  shift_sub_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept && !special),
    .step   ((state == S_CALC) && !flush),
    .is_div (func3[2]),
    .sgn_a  (signed_a(func3)),
    .sgn_b  (signed_b(func3)),
    .a      (operandA),
    .b      (operandB),
    .acc    (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (flush) nstate = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (start) nstate = special ? S_DONE : S_CALC;
        S_CALC:  if (cnt == CW'(1)) nstate = S_FIX;
        S_FIX:   nstate = S_DONE;
        S_DONE:  nstate = S_IDLE;
        default: nstate = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state == S_CALC) || (state == S_FIX);
    stall = busy || accept;
  end

  // Quotient sign follows the operand signs; remainder follows the dividend.
  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc : acc;
    quo  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op[2])                fix_res = op[1] ? rmd : quo;
    else if (op[1:0] == 2'b0) fix_res = prod[XLEN-1:0];
    else                      fix_res = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op     <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == S_DONE) && !flush;
      if (accept) begin
        op    <= func3;
        neg_a <= signed_a(func3) && operandA[XLEN-1];
        neg_b <= signed_b(func3) && operandB[XLEN-1];
        cnt   <= special ? '0 : CW'(XLEN);
        if (special) result <= special_res;
      end else if (flush) begin
        cnt <= '0;
      end else if (state == S_CALC) begin
        cnt <= cnt - CW'(1);
      end else if (state == S_FIX) begin
        result <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer: hand-computed RV32M results, latency, flush and reset behaviour.
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = 3'b0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        busy, stall, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_div_sequencer #(.XLEN(32)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .func3    (func3),
    .operandA (operandA),
    .operandB (operandB),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // lat = edges after the acceptance edge until done is seen.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int   n;
    logic seen, stall_ok;
    @(negedge clk);
    func3 = f; operandA = a; operandB = b; start = 1'b1;
    #1 chk({tag, "_stallreq"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; seen = 1'b0; stall_ok = 1'b1;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (n < lat && !stall) stall_ok = 1'b0;
    end
    chk({tag, "_lat"}, seen ? 32'(n - 1) : 32'hFFFF_FFFF, 32'(lat));
    chk({tag, "_res"}, result, exp);
    if (lat > 1) chk({tag, "_stall"}, 32'(stall_ok), 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int   seen;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", result, 32'd0);
    #10 rst_n = 1'b1;

    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    run_op("mulhu",  3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,        34);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,         34);
    run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,         1);
    run_op("divu0",  3'b101, 32'd9,        32'd0,        32'hFFFF_FFFF, 1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("divu2",  3'b101, 32'd100,      32'd7,        32'd14,        34);

    // flush in CALC cycle 10: back to IDLE, no done, result kept
    @(negedge clk);
    func3 = 3'b000; operandA = 32'd3; operandB = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    chk("fl_busy_pre", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_stall", 32'(stall), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("fl_nodone", 32'(seen), 32'd0);
    chk("fl_res", result, 32'd14);

    // flush and start together: flush wins
    @(negedge clk);
    func3 = 3'b101; operandA = 32'd50; operandB = 32'd5; start = 1'b1; flush = 1'b1;
    #1 chk("flst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flst_busy", 32'(busy), 32'd0);

    // start raised during the DONE-state cycle is ignored
    @(negedge clk);
    func3 = 3'b111; operandA = 32'd100; operandB = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 33; i++) @(negedge clk);
    chk("dn_busy_fix", 32'(busy), 32'd1);
    @(negedge clk);
    chk("dn_stall", 32'(stall), 32'd0);
    func3 = 3'b000; operandA = 32'd3; operandB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dn_done", 32'(done), 32'd1);
    chk("dn_res", result, 32'd2);
    chk("dn_ign", 32'(busy), 32'd0);
    @(negedge clk);
    chk("dn_ign2", 32'(busy), 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    func3 = 3'b011; operandA = 32'hFFFF_FFFF; operandB = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_stall", 32'(stall), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("ar_remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
